// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath word width, fetch FSM states, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Next sequential PC; wraps from all-ones to zero.
    function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit signal bundle: memory read port, IR handoff to decoder, redirect, control.
// Latency: n/a (wiring only).
// Backpressure: ir_valid/ir_ready handshake towards the decoder; mem_req/mem_ack towards memory.
interface instr_fetch_if
    import cpu_pkg::*;
;
    // control
    logic              halt;
    logic              bus_err;
    // instruction memory read port
    logic              mem_req;
    logic [WORD_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    // instruction register towards the decoder
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    // taken branch / jump
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;

    // Fetch unit side.
    modport master (
        input  halt,
        output bus_err,
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output ir,
        output ir_pc,
        output ir_valid,
        input  ir_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    // Memory / decoder / branch-unit side.
    modport slave (
        output halt,
        input  bus_err,
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  ir,
        input  ir_pc,
        input  ir_valid,
        output ir_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: reads mem[pc] into ir, hands it to the decoder, follows redirects.
// Latency: ir_valid rises 1 cycle after mem_ack; mem_req rises 1 cycle after leaving IDLE.
// Backpressure: holds ir until ir_ready, no new request meanwhile; gives up after TIMEOUT unacked cycles.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    // Next-state and datapath decisions; a redirect overrides everything else.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        bus_err_d  = bus_err_q;
        wait_d     = wait_q;

        if (bus.redirect_valid) begin
            // Any word returned this cycle belongs to the old path and is dropped.
            pc_d       = bus.redirect_pc;
            ir_valid_d = 1'b0;
            bus_err_d  = 1'b0;
            wait_d     = '0;
            state_d    = FETCH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.halt && !bus_err_q) begin
                        wait_d  = '0;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    // halt is deliberately not looked at here: an issued request completes.
                    if (bus.mem_ack) begin
                        ir_d       = bus.mem_rdata;
                        ir_pc_d    = pc_q;
                        pc_d       = pc_inc(pc_q);
                        ir_valid_d = 1'b1;
                        state_d    = HOLD;
                    end else if (wait_q == WAIT_LAST) begin
                        bus_err_d = 1'b1;
                        wait_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.ir_ready) begin
                        ir_valid_d = 1'b0;
                        wait_d     = '0;
                        state_d    = bus.halt ? IDLE : FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers; reset also abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            bus_err_q  <= bus_err_d;
            wait_q     <= wait_d;
        end
    end

    // Outputs come straight from registered state, no input-to-output paths.
    always_comb begin
        bus.mem_req  = (state_q == FETCH);
        bus.mem_addr = pc_q;
        bus.ir       = ir_q;
        bus.ir_pc    = ir_pc_q;
        bus.ir_valid = ir_valid_q;
        bus.bus_err  = bus_err_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the main flow, hand sequences for timeout and reset.
// Latency: each vector is applied for one clock edge and outputs are checked 1 ns after it.
// Backpressure: decoder ready and memory ack are driven explicitly per vector.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic clk;
    logic rst;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        halt;
        logic        ack;
        logic [15:0] rdata;
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_ir;
        logic [15:0] e_irpc;
        logic        e_v;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string name, input logic halt, input logic ack,
                                input logic [15:0] rdata, input logic rdy, input logic rv,
                                input logic [15:0] rpc, input logic e_req,
                                input logic [15:0] e_addr, input logic [15:0] e_ir,
                                input logic [15:0] e_irpc, input logic e_v, input logic e_err);
        vec_t v;
        v.name = name; v.halt = halt; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.rv = rv; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr; v.e_ir = e_ir;
        v.e_irpc = e_irpc; v.e_v = e_v; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input logic halt, input logic ack, input logic [15:0] rdata,
                         input logic rdy, input logic rv, input logic [15:0] rpc);
        bus.halt           = halt;
        bus.mem_ack        = ack;
        bus.mem_rdata      = rdata;
        bus.ir_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic req, input logic [15:0] addr,
                         input logic [15:0] ir, input logic [15:0] irpc, input logic v,
                         input logic err);
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.ir, bus.ir_pc, bus.ir_valid, bus.bus_err} !==
            {req, addr, ir, irpc, v, err}) begin
            errors++;
            $display("FAIL %s: got req=%b addr=%h ir=%h ir_pc=%h ir_valid=%b bus_err=%b, want req=%b addr=%h ir=%h ir_pc=%h ir_valid=%b bus_err=%b",
                     name, bus.mem_req, bus.mem_addr, bus.ir, bus.ir_pc, bus.ir_valid,
                     bus.bus_err, req, addr, ir, irpc, v, err);
        end
    endtask

    initial begin
        // Main flow: fields are inputs for one edge, then expected outputs after it.
        //                  name          halt ack rdata    rdy rv rpc       req addr     ir       ir_pc    v  err
        vecs.push_back(mk("idle_to_fetch", 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk("first_ack",     0, 1, 16'hC123, 0, 0, 16'h0000, 0, 16'h0001, 16'hC123, 16'h0000, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("hold_stray_ack", 0, 1, 16'h1111, 0, 0, 16'h0000, 0, 16'h0001, 16'hC123, 16'h0000, 1, 0));
        vecs.push_back(mk("consume",       0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0001, 16'hC123, 16'h0000, 0, 0));
        vecs.push_back(mk("wait_one",      0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 16'hC123, 16'h0000, 0, 0));
        vecs.push_back(mk("redir_vs_ack",  0, 1, 16'hBEEF, 0, 1, 16'h0040, 1, 16'h0040, 16'hC123, 16'h0000, 0, 0));
        vecs.push_back(mk("ack_at_40",     0, 1, 16'h1234, 0, 0, 16'h0000, 0, 16'h0041, 16'h1234, 16'h0040, 1, 0));
        vecs.push_back(mk("redir_and_rdy", 0, 0, 16'h0000, 1, 1, 16'hFFFF, 1, 16'hFFFF, 16'h1234, 16'h0040, 0, 0));
        vecs.push_back(mk("pc_wrap",       0, 1, 16'hABCD, 0, 0, 16'h0000, 0, 16'h0000, 16'hABCD, 16'hFFFF, 1, 0));
        vecs.push_back(mk("rdy_halt",      1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'hABCD, 16'hFFFF, 0, 0));
        vecs.push_back(mk("idle_halted",   1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'hABCD, 16'hFFFF, 0, 0));
        vecs.push_back(mk("unhalt",        0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 16'hABCD, 16'hFFFF, 0, 0));
        vecs.push_back(mk("halt_in_fetch", 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 16'hABCD, 16'hFFFF, 0, 0));
        vecs.push_back(mk("ack_halted",    1, 1, 16'h5A5A, 0, 0, 16'h0000, 0, 16'h0001, 16'h5A5A, 16'h0000, 1, 0));
        vecs.push_back(mk("consume2",      0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0001, 16'h5A5A, 16'h0000, 0, 0));

        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        step();
        step();
        check("reset_state", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].halt, vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            step();
            check(vecs[i].name, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ir,
                  vecs[i].e_irpc, vecs[i].e_v, vecs[i].e_err);
        end

        // Timeout: FETCH entered on the last vector; 15 unacked cycles raise bus_err.
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 14; i++) begin
            step();
            check("timeout_waiting", 1, 16'h0001, 16'h5A5A, 16'h0000, 0, 0);
        end
        step();
        check("timeout_fires", 0, 16'h0001, 16'h5A5A, 16'h0000, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_stays_idle", 0, 16'h0001, 16'h5A5A, 16'h0000, 0, 1);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010);
        step();
        check("redir_clears_err", 1, 16'h0010, 16'h5A5A, 16'h0000, 0, 0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

        // Reset asserted mid-FETCH, then stray acks while halted.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        drive(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stray_ack_after_rst", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        end
        drive(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
        step();
        check("ack_ignored_in_idle", 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        step();
        check("new_fetch_ack", 0, 16'h0001, 16'hDEAD, 16'h0000, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of cycles to wait for mem_ack.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port halt, input, 1 bit: when high, no new fetch starts.
REQ-006 The block SHALL have port mem_req, output, 1 bit: instruction memory read request.
REQ-007 The block SHALL have port mem_addr, output, 16 bits: read address, equal to pc.
REQ-008 The block SHALL have port mem_ack, input, 1 bit: read data valid this cycle.
REQ-009 The block SHALL have port mem_rdata, input, 16 bits: instruction word.
REQ-010 The block SHALL have port ir, output, 16 bits: instruction register driving the control-unit decoder.
REQ-011 The block SHALL have port ir_pc, output, 16 bits: address ir was fetched from.
REQ-012 The block SHALL have port ir_valid, output, 1 bit: ir holds an undelivered instruction.
REQ-013 The block SHALL have port ir_ready, input, 1 bit: the decoder consumes ir this cycle.
REQ-014 The block SHALL have port redirect_valid, input, 1 bit: a branch or jump is taken (BRZ, BRN or JUMP).
REQ-015 The block SHALL have port redirect_pc, input, 16 bits: branch or jump target.
REQ-016 The block SHALL have port bus_err, output, 1 bit: sticky fetch-timeout flag.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, FETCH and HOLD.
REQ-018 In IDLE, the FSM SHALL go to FETCH on the next edge if halt=0 and bus_err=0; otherwise it SHALL stay in IDLE.
REQ-019 mem_req SHALL be 1 exactly when the state is FETCH, and mem_addr SHALL always equal pc; both are decoded from registered state only.
REQ-020 In FETCH with mem_ack=1, the block SHALL load ir<=mem_rdata, ir_pc<=pc and pc<=pc+1, set ir_valid<=1, and go to HOLD; mem_ack may arrive in the first FETCH cycle.
REQ-021 Latency from mem_ack to ir_valid high SHALL be 1 cycle.
REQ-022 pc+1 SHALL wrap from 16'hFFFF to 16'h0000.
REQ-023 In FETCH, a wait counter SHALL count the cycles without mem_ack and SHALL clear on entry to FETCH.
REQ-024 When the wait counter reaches TIMEOUT with no ack, the block SHALL set bus_err<=1 and go to IDLE.
REQ-025 bus_err SHALL stay set until reset or redirect_valid.
REQ-026 In HOLD, ir and ir_pc SHALL be stable and ir_valid SHALL be 1.
REQ-027 In HOLD with ir_ready=1, the block SHALL set ir_valid<=0 and go to FETCH, or to IDLE if halt=1.
REQ-028 redirect_valid SHALL have priority over mem_ack, ir_ready, halt and timeout.
REQ-029 On redirect_valid in any state, the block SHALL load pc<=redirect_pc, clear ir_valid and bus_err, and go to FETCH.
REQ-030 If redirect_valid and mem_ack occur in the same cycle, the returned word SHALL be discarded and ir SHALL be unchanged.
REQ-031 If redirect_valid and ir_ready occur in the same cycle in HOLD, the instruction SHALL count as consumed and the redirect SHALL still apply.
REQ-032 mem_ack outside FETCH SHALL be ignored.
REQ-033 halt asserted during FETCH SHALL NOT abort the outstanding request; it SHALL only take effect at the next IDLE decision.
REQ-034 ir_pc SHALL let the datapath form PC-relative targets.

Reset
REQ-035 While rst=1, the block SHALL hold: state=IDLE, pc=RESET_PC, ir=16'h0000, ir_pc=16'h0000, ir_valid=0, bus_err=0, wait counter=0, hence mem_req=0.
REQ-036 Reset asserted mid-FETCH SHALL abandon the request, and a late mem_ack after reset SHALL be ignored unless it arrives in a new FETCH.

Structure
REQ-037 The shared package cpu_pkg SHALL hold WORD_W=16, the fetch state enum (IDLE, FETCH, HOLD) and the default RESET_PC.
REQ-038 The block SHALL be a single module with no sub-module; PC, IR, wait counter and FSM are local.

Verification
REQ-039 Reset, halt=0, memory acks the same cycle with data 16'hC123 at address 0 -> mem_req at cycle 1, ir=16'hC123, ir_pc=0, ir_valid the next cycle, pc=1.
REQ-040 ir_ready held 0 for 5 cycles -> ir stable, mem_req=0 throughout; ir_ready=1 -> mem_addr=1 the next cycle.
REQ-041 redirect_valid with redirect_pc=16'h0040 in the same cycle as mem_ack with data 16'hBEEF -> ir unchanged, next mem_addr=16'h0040.
REQ-042 pc=16'hFFFF, fetch completes -> ir_pc=16'hFFFF, mem_addr=16'h0000.
REQ-043 No mem_ack for 15 FETCH cycles -> bus_err=1, IDLE, no requests; redirect to 16'h0010 -> bus_err=0, mem_addr=16'h0010.
REQ-044 rst pulsed mid-FETCH, then a stray mem_ack -> all outputs at reset values, ir=16'h0000.
